// File: rtl/alu_div_seq_pkg.sv
// Shared constants for the sequenced divider: ALU funct codes, state encoding
// and the divide-by-zero quotient value.
package alu_div_seq_pkg;

  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUBU = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NEG_A = 3'd1,
    S_NEG_B = 3'd2,
    S_CMP   = 3'd3,
    S_SUB   = 3'd4,
    S_NEG_Q = 3'd5,
    S_NEG_R = 3'd6,
    S_DONE  = 3'd7
  } div_state_e;

  function automatic logic [31:0] shift_in(input logic [31:0] rem, input logic bit_in);
    return {rem[30:0], bit_in};
  endfunction

endpackage

// File: rtl/alu_div_seq.sv
// Restoring DIV/DIVU that borrows the shared combinational ALU for every
// subtraction, comparison and sign fix-up; one quotient bit per two cycles.
module alu_div_seq
  import alu_div_seq_pkg::*;
#(
  parameter int SIGNED_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [4:0]  alu_shamt,
  output logic [3:0]  alu_funct,
  input  logic [31:0] alu_result
);

  div_state_e  state, state_nxt;

  logic [31:0] a_q, b_q, rem_q, q_q;
  logic [4:0]  cnt;
  logic        sgn, ge, neg_q, neg_r;
  logic        mode_signed;
  logic [31:0] rem_sh, rem_nxt, q_nxt;
  logic        ovf;

  assign mode_signed = (SIGNED_EN != 0) && is_signed;

  // A set top bit before shifting means the shifted remainder is >= 2^32 > b,
  // so the wrapped 32-bit SUBU difference is the exact result.
  assign rem_sh  = shift_in(rem_q, a_q[cnt]);
  assign ovf     = rem_q[31];
  assign rem_nxt = ge ? alu_result : rem_sh;

  always_comb begin
    q_nxt      = q_q;
    q_nxt[cnt] = ge;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (divisor == 32'd0) state_nxt = S_DONE;
          else if (mode_signed) state_nxt = S_NEG_A;
          else                  state_nxt = S_CMP;
        end
      end
      S_NEG_A: state_nxt = S_NEG_B;
      S_NEG_B: state_nxt = S_CMP;
      S_CMP:   state_nxt = S_SUB;
      S_SUB: begin
        if (cnt != 5'd0) state_nxt = S_CMP;
        else if (sgn)    state_nxt = S_NEG_Q;
        else             state_nxt = S_DONE;
      end
      S_NEG_Q: state_nxt = S_NEG_R;
      S_NEG_R: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE) && (state != S_DONE);
    done      = (state == S_DONE);
    alu_shamt = 5'd0;
    alu_funct = ALU_ADDU;
    alu_op1   = 32'd0;
    alu_op2   = 32'd0;
    case (state)
      S_NEG_A: begin alu_funct = ALU_SUBU; alu_op2 = a_q;   end
      S_NEG_B: begin alu_funct = ALU_SUBU; alu_op2 = b_q;   end
      S_CMP:   begin alu_funct = ALU_SLTU; alu_op1 = rem_sh; alu_op2 = b_q; end
      S_SUB:   begin alu_funct = ALU_SUBU; alu_op1 = rem_sh; alu_op2 = b_q; end
      S_NEG_Q: begin alu_funct = ALU_SUBU; alu_op2 = q_q;   end
      S_NEG_R: begin alu_funct = ALU_SUBU; alu_op2 = rem_q; end
      default: ;
    endcase
  end

  // Working registers: contents only matter while busy, so no reset.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (start && divisor != 32'd0) begin
          a_q   <= dividend;
          b_q   <= divisor;
          cnt   <= 5'd31;
          rem_q <= 32'd0;
          sgn   <= mode_signed;
        end
      end
      S_NEG_A: begin
        if (a_q[31]) a_q <= alu_result;
        neg_q <= a_q[31];
        neg_r <= a_q[31];
      end
      S_NEG_B: begin
        if (b_q[31]) b_q <= alu_result;
        neg_q <= neg_q ^ b_q[31];
      end
      S_CMP: ge <= ovf | ~alu_result[0];
      S_SUB: begin
        rem_q <= rem_nxt;
        q_q   <= q_nxt;
        if (cnt != 5'd0) cnt <= cnt - 5'd1;
      end
      S_NEG_Q: if (neg_q) q_q <= alu_result;
      S_NEG_R: if (neg_r) rem_q <= alu_result;
      default: ;
    endcase
  end

  // Visible results change only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && divisor == 32'd0) begin
            quotient    <= DIV_ZERO_Q;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        S_SUB: begin
          if (cnt == 5'd0 && !sgn) begin
            quotient    <= q_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= 1'b0;
          end
        end
        S_NEG_R: begin
          quotient    <= q_q;
          remainder   <= neg_r ? alu_result : rem_q;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Bench for alu_div_seq: behavioural ALU attached to the alu_* ports and a
// plain-arithmetic reference for DIV/DIVU results and latency.
module tb_alu_div_seq;
  import alu_div_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_funct;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_div_seq #(.SIGNED_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_shamt(alu_shamt),
    .alu_funct(alu_funct), .alu_result(alu_result)
  );

  always_comb begin
    case (alu_funct)
      ALU_ADDU: alu_result = alu_op1 + alu_op2;
      ALU_SUBU: alu_result = alu_op1 - alu_op2;
      ALU_SLTU: alu_result = {31'd0, (alu_op1 < alu_op2)};
      default:  alu_result = 32'hDEAD_BEEF;
    endcase
  end

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z, output int lat);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1; lat = 1;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      q = qq[31:0]; r = rr[31:0]; z = 1'b0; lat = 69;
    end else begin
      q = a / b; r = a % b; z = 1'b0; lat = 65;
    end
  endfunction

  task automatic start_pulse(input logic [31:0] a, input logic [31:0] b, input logic sg);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; is_signed = sg;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output int bcnt,
                           output logic [31:0] q, output logic [31:0] r,
                           output logic z, output logic tmo, output logic shamt_bad);
    lat = lat0; bcnt = 0; shamt_bad = 1'b0;
    while (!done && lat < 300) begin
      if (busy) bcnt++;
      if (alu_shamt != 5'd0) shamt_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    tmo = !done;
    q = quotient; r = remainder; z = div_by_zero;
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        output int lat, output int bcnt, output logic [31:0] q,
                        output logic [31:0] r, output logic z, output logic tmo,
                        output logic shamt_bad);
    start_pulse(a, b, sg);
    wait_done(1, lat, bcnt, q, r, z, tmo, shamt_bad);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b dbz=%b q=%h r=%h required all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    total++;
    if (alu_op1 !== 32'd0 || alu_op2 !== 32'd0 || alu_funct !== ALU_ADDU || alu_shamt !== 5'd0) begin
      bad++;
      $display("FAIL reset_alu: op1=%h op2=%h funct=%h shamt=%h required 0/0/%h/0",
               alu_op1, alu_op2, alu_funct, alu_shamt, ALU_ADDU);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] ta [5] = '{32'd100, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_1234};
    logic [31:0] tb [5] = '{32'd7,   32'd7,         32'h8000_0001, 32'hFFFF_FFFF, 32'd0};
    logic        ts [5] = '{1'b0,    1'b1,          1'b0,          1'b1,          1'b0};
    logic [31:0] eq [5] = '{32'd14,  32'hFFFF_FFF2, 32'd1,         32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] er [5] = '{32'd2,   32'hFFFF_FFFE, 32'h7FFF_FFFE, 32'd0,         32'h0000_1234};
    logic        ez [5] = '{1'b0,    1'b0,          1'b0,          1'b0,          1'b1};
    int          el [5] = '{65,      69,            65,            69,            1};
    int          eb [5] = '{64,      68,            64,            68,            0};
    int lat, bcnt;
    logic [31:0] q, r;
    logic z, tmo, sb;
    for (int i = 0; i < 5; i++) begin
      do_div(ta[i], tb[i], ts[i], lat, bcnt, q, r, z, tmo, sb);
      total++;
      if (tmo || lat != el[i]) begin
        bad++;
        $display("FAIL directed%0d_latency: got %0d (timeout=%b) required %0d", i, lat, tmo, el[i]);
      end
      total++;
      if (q !== eq[i] || r !== er[i] || z !== ez[i]) begin
        bad++;
        $display("FAIL directed%0d_result: q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                 i, q, r, z, eq[i], er[i], ez[i]);
      end
      total++;
      if (bcnt != eb[i]) begin
        bad++;
        $display("FAIL directed%0d_busy_cycles: got %0d required %0d", i, bcnt, eb[i]);
      end
    end
  endtask

  task automatic test_ignored_start;
    int lat, bcnt;
    logic [31:0] q, r, eq, er;
    logic z, ez, tmo, sb;
    int el;
    ref_div(32'd1000, 32'd33, 1'b0, eq, er, ez, el);
    start_pulse(32'd1000, 32'd33, 1'b0);
    repeat (8) @(negedge clk);
    start = 1'b1; dividend = 32'd77; divisor = 32'd0; is_signed = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(10, lat, bcnt, q, r, z, tmo, sb);
    total++;
    if (tmo || lat != el || q !== eq || r !== er || z !== ez) begin
      bad++;
      $display("FAIL ignored_start: lat=%0d q=%h r=%h dbz=%b required lat=%0d q=%h r=%h dbz=%b",
               lat, q, r, z, el, eq, er, ez);
    end
    // start raised during the DONE cycle must not launch anything
    start = 1'b1; dividend = 32'd5; divisor = 32'd0; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== eq || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL start_in_done: busy=%b done=%b q=%h dbz=%b required 0/0/%h/0",
               busy, done, quotient, div_by_zero, eq);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, seen;
    logic [31:0] q, r;
    logic z, tmo, sb;
    start_pulse(32'd999, 32'd10, 1'b1);
    repeat (28) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0 ||
        alu_op1 !== 32'd0 || alu_op2 !== 32'd0 || alu_funct !== ALU_ADDU) begin
      bad++;
      $display("FAIL reset_mid_state: busy=%b done=%b dbz=%b q=%h r=%h op1=%h op2=%h funct=%h required idle zeros",
               busy, done, div_by_zero, quotient, remainder, alu_op1, alu_op2, alu_funct);
    end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_mid_no_done: %0d active cycles after abort, required 0", seen);
    end
    do_div(32'd12, 32'd4, 1'b0, lat, bcnt, q, r, z, tmo, sb);
    total++;
    if (tmo || q !== 32'd3 || r !== 32'd0 || z !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_div: q=%h r=%h dbz=%b timeout=%b required 3/0/0", q, r, z, tmo);
    end
  endtask

  task automatic test_random;
    int lat, bcnt, el;
    logic [31:0] a, b, q, r, eq, er;
    logic sg, z, ez, tmo, sb;
    for (int i = 0; i < 24; i++) begin
      a  = $urandom;
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      ref_div(a, b, sg, eq, er, ez, el);
      do_div(a, b, sg, lat, bcnt, q, r, z, tmo, sb);
      total++;
      if (tmo || lat != el || q !== eq || r !== er || z !== ez || sb) begin
        bad++;
        $display("FAIL random%0d a=%h b=%h s=%b: lat=%0d q=%h r=%h dbz=%b shamt_bad=%b required lat=%0d q=%h r=%h dbz=%b",
                 i, a, b, sg, lat, q, r, z, sb, el, eq, er, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_div_seq.md
Name: alu_div_seq

Overview:
- Multi-cycle integer divider that sequences the shared 32-bit combinational ALU to perform DIV/DIVU (restoring division), instead of using a dedicated subtractor.
- Sits beside the EX stage. It owns the ALU input mux while busy and drives funct/operands each cycle. The ALU result returns combinationally in the same cycle.
- The pipeline stalls on busy.

Parameters:
- SIGNED_EN, 1: 1 = is_signed honoured; 0 = is_signed ignored, always unsigned.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  signed divide when 1 (sampled with start)
- dividend  in  32  sampled with start
- divisor  in  32  sampled with start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse, results valid
- quotient  out  32  held until next accepted start
- remainder  out  32  held until next accepted start
- div_by_zero  out  1  valid with done; held
- alu_op1  out  32  to ALU operand1
- alu_op2  out  32  to ALU operand2
- alu_shamt  out  5  to ALU shamt; always 0
- alu_funct  out  4  to ALU funct (GLOBAL ALU codes)
- alu_result  in  32  from ALU

Behaviour:
- One clock (clk); rst synchronous, active-high.
- On reset: state=IDLE; busy, done, div_by_zero=0; quotient, remainder=0; alu_op1, alu_op2=0; alu_funct=ALU_ADDU.
- Reset mid-operation aborts immediately with the same values; no done.
- States: IDLE, NEG_A, NEG_B, CMP, SUB, NEG_Q, NEG_R, DONE.
- IDLE, start=1, divisor==0:
  - Next state is DONE.
  - quotient=32'hFFFFFFFF, remainder=dividend (unmodified), div_by_zero=1.
  - No ALU use.
- IDLE, start=1, divisor!=0:
  - Latch operands and mode; cnt=31; rem=0.
  - Signed mode goes to NEG_A; unsigned goes to CMP.
- NEG_A: funct=ALU_SUBU, op1=0, op2=a. Take the result if a[31]. Go to NEG_B.
- NEG_B: same as NEG_A for b. Go to CMP.
  - Record neg_q = sign_a^sign_b and neg_r = sign_a.
  - Both negation cycles are always spent in signed mode, even for nonnegative operands (fixed latency).
- Per quotient bit:
  - rem_sh = {rem[30:0], a[cnt]} (combinational); ovf = rem[31].
  - CMP: funct=ALU_SLTU, op1=rem_sh, op2=b. Register ge = ovf | ~alu_result[0]. Go to SUB.
  - SUB: funct=ALU_SUBU, op1=rem_sh, op2=b.
    - rem = ge ? alu_result : rem_sh; q[cnt] = ge.
    - If cnt==0, go to NEG_Q (signed) or DONE (unsigned); else cnt--, go to CMP.
  - 32-bit wrap of SUBU is intentional: when ovf=1 the true difference fits in 32 bits.
- NEG_Q, NEG_R: SUBU 0-x. Take the result if neg_q or neg_r respectively. Then go to DONE.
- DONE:
  - done=1 for exactly one cycle; quotient and remainder registered and stable.
  - Next state IDLE; busy=0 in DONE.
- Latency (start edge to done cycle):
  - unsigned: 65 edges
  - signed: 69 edges
  - divide-by-zero: 1 edge
- start while not in IDLE is ignored (no queueing). start in the DONE cycle is ignored.
- Signed -2^31 / -1 gives quotient=0x80000000, remainder=0, no flag.
- Remainder sign follows the dividend; quotient truncates toward zero.
- Outside the NEG/CMP/SUB states: alu_funct=ALU_ADDU, operands 0.

Decomposition:
- ALU funct codes (ALU_SUBU, ALU_SLTU, ALU_ADDU) come from the shared GLOBAL include. No new codes are introduced.
- Add the state encoding (3-bit) and DIV_ZERO_Q (32'hFFFFFFFF) as shared constants.
- No sub-module. The bench instantiates ALU and connects it to the alu_* ports.

Test Plan:
- Unsigned 100/7, is_signed=0 -> done at edge 65; quotient=14, remainder=2, div_by_zero=0, busy high for 64 cycles.
- Signed -100/7 -> done at edge 69; quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2).
- Unsigned 0xFFFFFFFF/0x80000001 (ovf path) -> quotient=1, remainder=0x7FFFFFFE. Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- divisor=0, dividend=0x1234 -> done at edge 1; quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- Second start pulse at cycle 10 with new operands -> ignored; first result is unchanged.
- rst asserted at cycle 30 -> next cycle IDLE with all outputs 0 and no done pulse. A new start 12/4 then gives quotient=3, remainder=0.
